// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, so an
// operation occupies log2(WIDTH) cycles. A single global advance term stalls
// every stage together under backpressure, so ordering is always preserved.
module pipelined_shift_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH),
   parameter int unsigned TAG_W   = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_zero,
   output logic               busy
);

   localparam int unsigned L = SHAMT_W;

   localparam logic [1:0] OpSll = 2'b00;
   localparam logic [1:0] OpSrl = 2'b01;
   localparam logic [1:0] OpSra = 2'b10;

   // Stage registers
   logic [L-1:0]                 r_valid;
   logic [L-1:0][WIDTH-1:0]      r_data;
   logic [L-1:0][SHAMT_W-1:0]    r_shamt;
   logic [L-1:0][1:0]            r_op;
   logic [L-1:0][TAG_W-1:0]      r_tag;

   // Per-stage source (predecessor) and shifted next data
   logic [L-1:0]                 w_src_valid;
   logic [L-1:0][WIDTH-1:0]      w_src_data;
   logic [L-1:0][SHAMT_W-1:0]    w_src_shamt;
   logic [L-1:0][1:0]            w_src_op;
   logic [L-1:0][TAG_W-1:0]      w_src_tag;
   logic [L-1:0][WIDTH-1:0]      w_nxt_data;

   logic                         w_advance;
   logic                         w_unused_shamt;

   // Fixed-distance shift; amt is a power of two in 1..WIDTH/2.
   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       op,
                                                 input int unsigned      amt);
      logic [WIDTH-1:0] res;
      case (op)
         OpSll:   res = d << amt;
         OpSrl:   res = d >> amt;
         // MSB is invariant under SRA, so the current MSB is the original sign
         OpSra:   res = $signed(d) >>> amt;
         default: res = (d << amt) | (d >> (WIDTH - amt));
      endcase
      return res;
   endfunction

   for (genvar k = 0; k < L; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign w_src_valid[k] = in_valid;
         assign w_src_data[k]  = in_data;
         assign w_src_shamt[k] = in_shamt;
         assign w_src_op[k]    = in_op;
         assign w_src_tag[k]   = in_tag;
      end else begin : g_rest
         assign w_src_valid[k] = r_valid[k-1];
         assign w_src_data[k]  = r_data[k-1];
         assign w_src_shamt[k] = r_shamt[k-1];
         assign w_src_op[k]    = r_op[k-1];
         assign w_src_tag[k]   = r_tag[k-1];
      end
      // Stage k contributes a 2^k shift when shamt bit k is set
      assign w_nxt_data[k] = w_src_shamt[k][k] ?
                             f_shift(w_src_data[k], w_src_op[k], 32'd1 << k) :
                             w_src_data[k];
   end

   // Empty output slot or a consuming sink lets the whole pipe move
   assign w_advance = !r_valid[L-1] || out_ready;

   // Advance all stages together, or hold all of them (bubbles included)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         r_data  <= '0;
         r_shamt <= '0;
         r_op    <= '0;
         r_tag   <= '0;
      end else if (w_advance) begin
         r_valid <= w_src_valid;
         r_data  <= w_nxt_data;
         r_shamt <= w_src_shamt;
         r_op    <= w_src_op;
         r_tag   <= w_src_tag;
      end
   end

   // The final stage's shift amount has no consumer
   assign w_unused_shamt = ^r_shamt[L-1];

   assign in_ready  = w_advance;
   assign out_valid = r_valid[L-1];
   assign out_data  = r_data[L-1];
   assign out_tag   = r_tag[L-1];
   assign out_zero  = (r_data[L-1] == '0);
   assign busy      = |r_valid;

endmodule
